// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter and future load/store units:
// funct3 size codes, byte-strobe generation and access legality.
package mem_arb_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // What the data port needs to remember about an accepted request
  typedef struct packed {
    logic       err;
    logic       load;
    logic [1:0] off;
    logic [2:0] size;
  } d_rsp_t;

  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] strobe;
    case (size)
      SZ_B, SZ_BU: strobe = 4'b0001 << off;
      SZ_H, SZ_HU: strobe = 4'b0011 << off;
      SZ_W:        strobe = 4'b1111;
      default:     strobe = 4'b0000;
    endcase
    return strobe;
  endfunction

  // Misaligned, undefined size, or a store using an unsigned-load encoding
  function automatic logic access_err(input logic [2:0] size, input logic [1:0] off,
                                      input logic we);
    logic err;
    case (size)
      SZ_B:    err = 1'b0;
      SZ_BU:   err = we;
      SZ_H:    err = off[0];
      SZ_HU:   err = we | off[0];
      SZ_W:    err = |off;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response ports plus the RAM port of the arbiter.
// slave is the arbiter's view; master is the core-plus-RAM side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_data;

  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_we;
  logic [2:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_rsp_valid;
  logic [31:0]       d_rsp_data;
  logic              d_rsp_err;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req_valid, if_addr, d_req_valid, d_we, d_size, d_addr, d_wdata, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req_valid, if_addr, d_req_valid, d_we, d_size, d_addr, d_wdata, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Picks the byte/half/word of a RAM word at a byte offset and extends it
// according to the funct3 load size.
module mem_load_align
  import mem_arb_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = word_i[gi*8 +: 8];
  end

  assign byte_sel = lane[off_i];
  assign half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    case (size_i)
      SZ_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   data_o = {24'h000000, byte_sel};
      SZ_H:    data_o = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   data_o = {16'h0000, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one single-ported RAM,
// steering store lanes and returning aligned load data one cycle later.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_port_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic             grant_if;
  logic             grant_d;
  logic             d_err;
  logic             starve_hit;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             if_pend_q;
  logic             d_pend_q;
  d_rsp_t           d_rsp_q, d_rsp_d;
  logic [31:0]      load_data;
  logic [7:0]       lane_wdata [4];
  logic             unused_fetch_lsbs;

  // Data normally wins; fetch is forced through once it has lost STARVE_MAX times in a row
  assign starve_hit = (starve_q == CNT_W'(STARVE_MAX));
  assign grant_if   = bus.if_req_valid && (!bus.d_req_valid || starve_hit);
  assign grant_d    = bus.d_req_valid && !grant_if;
  assign d_err      = access_err(bus.d_size, bus.d_addr[1:0], bus.d_we);

  assign bus.if_req_ready = grant_if;
  assign bus.d_req_ready  = grant_d;

  always_comb begin
    starve_d = '0;
    if (bus.if_req_valid && !grant_if)
      starve_d = starve_hit ? starve_q : starve_q + 1'b1;
  end

  assign d_rsp_d = '{err: d_err, load: !bus.d_we, off: bus.d_addr[1:0], size: bus.d_size};

  assign bus.mem_en   = grant_if || (grant_d && !d_err);
  assign bus.mem_addr = grant_if ? bus.if_addr[ADDR_W-1:2] : bus.d_addr[ADDR_W-1:2];
  assign bus.mem_we   = (grant_d && bus.d_we && !d_err) ? byte_strobe(bus.d_size, bus.d_addr[1:0])
                                                       : 4'b0000;

  for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
    assign lane_wdata[gi] = (bus.d_size == SZ_W)                        ? bus.d_wdata[gi*8 +: 8] :
                            (bus.d_size == SZ_H || bus.d_size == SZ_HU) ? bus.d_wdata[(gi%2)*8 +: 8] :
                                                                          bus.d_wdata[7:0];
  end
  assign bus.mem_wdata = {lane_wdata[3], lane_wdata[2], lane_wdata[1], lane_wdata[0]};

  // Fetch addresses are word aligned by contract
  assign unused_fetch_lsbs = ^bus.if_addr[1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_q  <= '0;
      if_pend_q <= 1'b0;
      d_pend_q  <= 1'b0;
      d_rsp_q   <= '0;
    end else begin
      starve_q  <= starve_d;
      if_pend_q <= grant_if;
      d_pend_q  <= grant_d;
      d_rsp_q   <= d_rsp_d;
    end
  end

  mem_load_align u_load_align (
    .word_i (bus.mem_rdata),
    .off_i  (d_rsp_q.off),
    .size_i (d_rsp_q.size),
    .data_o (load_data)
  );

  // Gating with reset_n drops a response whose request was accepted just before reset
  assign bus.if_rsp_valid = if_pend_q && reset_n;
  assign bus.if_rsp_data  = bus.if_rsp_valid ? bus.mem_rdata : 32'h0;
  assign bus.d_rsp_valid  = d_pend_q && reset_n;
  assign bus.d_rsp_err    = bus.d_rsp_valid && d_rsp_q.err;
  assign bus.d_rsp_data   = (bus.d_rsp_valid && d_rsp_q.load && !d_rsp_q.err) ? load_data : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a byte-level
// memory model and a grant model derived from the arbitration rules.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 14;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic clear_ram;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // RAM behind the arbiter: registered read, byte-enabled write
  logic [31:0] ram [4096];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (clear_ram) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 32'h0;
    end else if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) ram[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      rdata_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rdata_q;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0]  shadow [16384];
  int          starve_m;
  bit          f_pend, d_pend, g_if, g_d, e_err;
  logic [13:0] f_addr, d_addr_r;
  logic        d_we_r;
  logic [2:0]  d_sz;
  logic [31:0] d_wd, v, e_wd, e_mask;
  logic [3:0]  e_we;
  int          nb, off;
  bit          exp_if_v, exp_d_v, exp_d_err;
  logic [31:0] exp_if_data, exp_d_data;

  logic [13:0] la [8];
  logic [2:0]  ls [8];
  logic [31:0] le [8];
  logic [13:0] ea [5];
  logic [2:0]  es [5];
  logic        ew [5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req_valid = 1'b0;
    bus.d_req_valid  = 1'b0;
  endtask

  task automatic drive_d(input logic we, input logic [2:0] sz, input logic [13:0] a,
                         input logic [31:0] wd);
    bus.d_req_valid = 1'b1;
    bus.d_we        = we;
    bus.d_size      = sz;
    bus.d_addr      = a;
    bus.d_wdata     = wd;
  endtask

  function automatic bit m_err(input logic [2:0] sz, input logic [1:0] o, input logic we);
    case (sz)
      3'b000:  return 1'b0;
      3'b100:  return we;
      3'b001:  return o[0];
      3'b101:  return we || o[0];
      3'b010:  return o != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int m_bytes(input logic [2:0] sz);
    if (sz == 3'b010) return 4;
    if (sz == 3'b001 || sz == 3'b101) return 2;
    return 1;
  endfunction

  initial begin
    la = '{14'h0102, 14'h0102, 14'h0102, 14'h0100, 14'h0101, 14'h0100, 14'h0102, 14'h0103};
    ls = '{3'b000,   3'b100,   3'b101,   3'b001,   3'b000,   3'b010,   3'b001,   3'b100};
    le = '{32'hFFFFFFF4, 32'h000000F4, 32'h000012F4, 32'h00003456,
           32'h00000034, 32'h12F43456, 32'h000012F4, 32'h00000012};
    ea = '{14'h0006, 14'h0101, 14'h0100, 14'h0100, 14'h0102};
    es = '{3'b010,   3'b001,   3'b011,   3'b100,   3'b010};
    ew = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b1};
    for (int i = 0; i < 16384; i++) shadow[i] = 8'h00;

    reset_n   = 1'b0;
    clear_ram = 1'b1;
    idle();
    bus.if_addr = '0;
    drive_d(1'b0, 3'b010, '0, '0);
    bus.d_req_valid = 1'b0;
    next_cycle();
    clear_ram = 1'b0;
    next_cycle();
    chk("reset if_rsp_valid", 32'(bus.if_rsp_valid), 0);
    chk("reset d_rsp_valid", 32'(bus.d_rsp_valid), 0);
    chk("reset d_rsp_err", 32'(bus.d_rsp_err), 0);
    chk("reset d_rsp_data", bus.d_rsp_data, 0);
    chk("reset if_rsp_data", bus.if_rsp_data, 0);
    reset_n = 1'b1;
    next_cycle();

    // Word stores that set up the instruction word and the load-test word
    drive_d(1'b1, 3'b010, 14'h0010, 32'h00500093);
    #1;
    chk("sw0 d_req_ready", 32'(bus.d_req_ready), 1);
    chk("sw0 mem_we", 32'(bus.mem_we), 32'hF);
    chk("sw0 mem_addr", 32'(bus.mem_addr), 32'h004);
    next_cycle();
    drive_d(1'b1, 3'b010, 14'h0100, 32'h12F43456);
    chk("sw0 d_rsp_valid", 32'(bus.d_rsp_valid), 1);
    chk("sw0 d_rsp_data", bus.d_rsp_data, 0);
    #1;
    chk("sw1 mem_wdata", bus.mem_wdata, 32'h12F43456);
    chk("sw1 mem_addr", 32'(bus.mem_addr), 32'h040);
    next_cycle();
    idle();
    chk("sw1 d_rsp_valid", 32'(bus.d_rsp_valid), 1);

    bus.if_req_valid = 1'b1;
    bus.if_addr      = 14'h0010;
    #1;
    chk("fetch if_req_ready", 32'(bus.if_req_ready), 1);
    chk("fetch mem_en", 32'(bus.mem_en), 1);
    chk("fetch mem_addr", 32'(bus.mem_addr), 32'h004);
    chk("fetch mem_we", 32'(bus.mem_we), 0);
    next_cycle();
    idle();
    chk("fetch if_rsp_valid", 32'(bus.if_rsp_valid), 1);
    chk("fetch if_rsp_data", bus.if_rsp_data, 32'h00500093);
    chk("fetch d_rsp_valid", 32'(bus.d_rsp_valid), 0);

    // Back-to-back loads from 0x12F43456
    for (int i = 0; i < 8; i++) begin
      drive_d(1'b0, ls[i], la[i], 32'h0);
      #1;
      chk($sformatf("load%0d d_req_ready", i), 32'(bus.d_req_ready), 1);
      chk($sformatf("load%0d mem_en", i), 32'(bus.mem_en), 1);
      next_cycle();
      chk($sformatf("load%0d d_rsp_valid", i), 32'(bus.d_rsp_valid), 1);
      chk($sformatf("load%0d d_rsp_data", i), bus.d_rsp_data, le[i]);
      chk($sformatf("load%0d d_rsp_err", i), 32'(bus.d_rsp_err), 0);
    end

    drive_d(1'b1, 3'b000, 14'h0103, 32'h000000AB);
    #1;
    chk("sb mem_we", 32'(bus.mem_we), 32'h8);
    chk("sb mem_wdata", bus.mem_wdata, 32'hABABABAB);
    chk("sb mem_addr", 32'(bus.mem_addr), 32'h040);
    next_cycle();
    chk("sb d_rsp_valid", 32'(bus.d_rsp_valid), 1);
    chk("sb d_rsp_data", bus.d_rsp_data, 0);
    drive_d(1'b0, 3'b001, 14'h0102, 32'h0);
    next_cycle();
    chk("lh neg d_rsp_data", bus.d_rsp_data, 32'hFFFFABF4);

    for (int i = 0; i < 5; i++) begin
      drive_d(ew[i], es[i], ea[i], 32'hDEADBEEF);
      #1;
      chk($sformatf("err%0d d_req_ready", i), 32'(bus.d_req_ready), 1);
      chk($sformatf("err%0d mem_en", i), 32'(bus.mem_en), 0);
      chk($sformatf("err%0d mem_we", i), 32'(bus.mem_we), 0);
      next_cycle();
      chk($sformatf("err%0d d_rsp_valid", i), 32'(bus.d_rsp_valid), 1);
      chk($sformatf("err%0d d_rsp_err", i), 32'(bus.d_rsp_err), 1);
      chk($sformatf("err%0d d_rsp_data", i), bus.d_rsp_data, 0);
    end
    idle();
    next_cycle();

    // Both requesters valid: expect D,D,D,D,I,D,D,D,D,I
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 14'h0010;
    drive_d(1'b0, 3'b010, 14'h0100, 32'h0);
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("starve%0d if_req_ready", c), 32'(bus.if_req_ready), (c == 4 || c == 9) ? 1 : 0);
      chk($sformatf("starve%0d d_req_ready", c), 32'(bus.d_req_ready), (c == 4 || c == 9) ? 0 : 1);
      next_cycle();
      chk($sformatf("starve%0d if_rsp_valid", c), 32'(bus.if_rsp_valid), (c == 4 || c == 9) ? 1 : 0);
      chk($sformatf("starve%0d d_rsp_valid", c), 32'(bus.d_rsp_valid), (c == 4 || c == 9) ? 0 : 1);
    end

    // Build up starvation, then reset right after a load is accepted
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("prerst%0d d_req_ready", c), 32'(bus.d_req_ready), 1);
      next_cycle();
    end
    reset_n = 1'b0;
    #1;
    chk("rst_mid d_rsp_valid", 32'(bus.d_rsp_valid), 0);
    chk("rst_mid d_rsp_data", bus.d_rsp_data, 0);
    next_cycle();
    reset_n = 1'b1;
    chk("rst_after d_rsp_valid", 32'(bus.d_rsp_valid), 0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("postrst%0d if_req_ready", c), 32'(bus.if_req_ready), (c == 4) ? 1 : 0);
      next_cycle();
    end
    idle();
    next_cycle();
    next_cycle();

    // Randomized traffic against the model, in an area the directed steps left untouched
    starve_m  = 0;
    f_pend    = 1'b0;
    d_pend    = 1'b0;
    exp_if_v  = 1'b0;
    exp_d_v   = 1'b0;
    exp_d_err = 1'b0;
    exp_if_data = 32'h0;
    exp_d_data  = 32'h0;
    for (int i = 0; i < 400; i++) begin
      chk($sformatf("rnd%0d if_rsp_valid", i), 32'(bus.if_rsp_valid), 32'(exp_if_v));
      if (exp_if_v) chk($sformatf("rnd%0d if_rsp_data", i), bus.if_rsp_data, exp_if_data);
      chk($sformatf("rnd%0d d_rsp_valid", i), 32'(bus.d_rsp_valid), 32'(exp_d_v));
      chk($sformatf("rnd%0d d_rsp_err", i), 32'(bus.d_rsp_err), 32'(exp_d_err));
      chk($sformatf("rnd%0d d_rsp_data", i), bus.d_rsp_data, exp_d_data);

      if (!f_pend && $urandom_range(0, 3) != 0) begin
        f_pend = 1'b1;
        f_addr = 14'h0200 + 14'($urandom_range(0, 255));
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend   = 1'b1;
        d_addr_r = 14'h0200 + 14'($urandom_range(0, 255));
        d_we_r   = 1'($urandom_range(0, 1));
        d_wd     = $urandom;
        case ($urandom_range(0, 9))
          0, 1:    d_sz = 3'b000;
          2, 3:    d_sz = 3'b001;
          4, 5:    d_sz = 3'b010;
          6:       d_sz = 3'b100;
          7:       d_sz = 3'b101;
          8:       d_sz = 3'b011;
          default: d_sz = ($urandom_range(0, 1) != 0) ? 3'b110 : 3'b111;
        endcase
      end
      bus.if_req_valid = f_pend;
      bus.if_addr      = f_addr;
      bus.d_req_valid  = d_pend;
      bus.d_we         = d_we_r;
      bus.d_size       = d_sz;
      bus.d_addr       = d_addr_r;
      bus.d_wdata      = d_wd;
      #1;

      g_if  = f_pend && (!d_pend || starve_m == STARVE_MAX);
      g_d   = d_pend && !g_if;
      e_err = m_err(d_sz, d_addr_r[1:0], d_we_r);
      nb    = m_bytes(d_sz);
      off   = int'(d_addr_r[1:0]);
      chk($sformatf("rnd%0d if_req_ready", i), 32'(bus.if_req_ready), 32'(g_if));
      chk($sformatf("rnd%0d d_req_ready", i), 32'(bus.d_req_ready), 32'(g_d));
      chk($sformatf("rnd%0d mem_en", i), 32'(bus.mem_en), 32'(g_if || (g_d && !e_err)));

      exp_if_v  = g_if;
      exp_d_v   = g_d;
      exp_d_err = g_d && e_err;
      exp_d_data = 32'h0;
      if (g_if) begin
        exp_if_data = 32'h0;
        for (int k = 0; k < 4; k++)
          exp_if_data = exp_if_data | ({24'h0, shadow[{f_addr[13:2], 2'b00} + 14'(k)]} << (8*k));
      end
      if (g_d && !e_err && d_we_r) begin
        e_we   = 4'b0000;
        e_wd   = 32'h0;
        e_mask = 32'h0;
        for (int k = 0; k < nb; k++) begin
          e_we[off + k]          = 1'b1;
          e_wd[(off+k)*8 +: 8]   = d_wd[k*8 +: 8];
          e_mask[(off+k)*8 +: 8] = 8'hFF;
          shadow[d_addr_r + 14'(k)] = d_wd[k*8 +: 8];
        end
        chk($sformatf("rnd%0d mem_we", i), 32'(bus.mem_we), 32'(e_we));
        chk($sformatf("rnd%0d mem_wdata", i), bus.mem_wdata & e_mask, e_wd);
        chk($sformatf("rnd%0d mem_addr", i), 32'(bus.mem_addr), 32'(d_addr_r[13:2]));
      end else begin
        chk($sformatf("rnd%0d mem_we idle", i), 32'(bus.mem_we), 0);
      end
      if (g_d && !e_err && !d_we_r) begin
        v = 32'h0;
        for (int k = 0; k < nb; k++)
          v = v | ({24'h0, shadow[d_addr_r + 14'(k)]} << (8*k));
        if (d_sz == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
        if (d_sz == 3'b001 && v[15]) v = v | 32'hFFFF0000;
        exp_d_data = v;
      end

      if (f_pend && !g_if) starve_m = (starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX;
      else                 starve_m = 0;
      if (g_if) f_pend = 1'b0;
      if (g_d)  d_pend = 1'b0;
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
